// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and the MEM/WB register payload.
// The load-misalignment trap is enabled by defining LOAD_MISALIGN_TRAP_EN.
package mips_pkg;

  // Data-memory opcodes
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_reg_t;

  // Halfword loads need 2-byte alignment, word loads need 4-byte alignment.
  function automatic logic is_misaligned(input logic [5:0] opcode,
                                         input logic [1:0] offset);
    case (opcode)
      OP_LH, OP_LHU: return offset[0];
      OP_LW:         return offset != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Big-endian lane select and sign/zero extension of a data-memory read word.
// Halfword lanes use offset[1] only; word loads ignore the offset.
module load_extend
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    byte_sel = word[31:24];
    case (offset)
      2'd0: byte_sel = word[31:24];
      2'd1: byte_sel = word[23:16];
      2'd2: byte_sel = word[15:8];
      2'd3: byte_sel = word[7:0];
      default: byte_sel = word[31:24];
    endcase
  end

  assign half_sel = offset[1] ? word[15:0] : word[31:16];

  always_comb begin
    value = word;
    case (opcode)
      OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  value = {24'h0, byte_sel};
      OP_LH:   value = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  value = {16'h0, half_sel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extension, stall/flush control and $zero write suppression.
// Define LOAD_MISALIGN_TRAP_EN to add the registered misalign_exc output.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32  // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        rd_addr,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
`ifdef LOAD_MISALIGN_TRAP_EN
  ,
  output logic              misalign_exc
`endif
);

  wb_reg_t     q;
  wb_reg_t     d;
  logic [31:0] load_value;

  load_extend u_load_extend (
    .opcode (opcode),
    .offset (alu_result[1:0]),
    .word   (mem_data),
    .value  (load_value)
  );

`ifdef LOAD_MISALIGN_TRAP_EN
  logic misaligned;
  logic exc_q;
  assign misaligned = is_misaligned(opcode, alu_result[1:0]);
`endif

  always_comb begin
    d.valid     = 1'b1;
    d.reg_write = reg_write && (rd_addr != 5'd0);
    d.rd        = rd_addr;
    d.data      = mem_to_reg ? load_value : alu_result;
`ifdef LOAD_MISALIGN_TRAP_EN
    if (misaligned) d.reg_write = 1'b0;
`endif
  end

  // Flush beats stall; an idle MEM stage loads the same bubble as a flush.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all fields sample pre-edge values.
    if (reset)          q <= '0;
    else if (flush)     q <= '0;
    else if (!stall)    q <= in_valid ? d : '0;
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          exc_q <= 1'b0;
    else if (flush)     exc_q <= 1'b0;
    else if (!stall)    exc_q <= in_valid && misaligned;
  end
  assign misalign_exc = exc_q;
`endif

  assign wb_valid     = q.valid;
  assign wb_reg_write = q.reg_write;
  assign wb_rd        = q.rd;
  assign wb_data      = q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed load/stall/flush/reset vectors
// against an arithmetic reference model compared every falling edge.
module tb_mem_wb_stage;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] ADD = 6'b000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] mem_data = '0, alu_result = '0;
  logic [4:0]  rd_addr = '0;
  logic        reg_write = 1'b0, mem_to_reg = 1'b0;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LOAD_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  mem_wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .opcode       (opcode),
    .mem_data     (mem_data),
    .alu_result   (alu_result),
    .rd_addr      (rd_addr),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
`ifdef LOAD_MISALIGN_TRAP_EN
    ,
    .misalign_exc (misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the wb_* outputs must show.
  logic        m_valid = 1'b0, m_rw = 1'b0, m_exc = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [5:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - int'(a)))) & 32'hFF;
    h = (a >= 2) ? (w & 32'hFFFF) : (w >> 16);
    case (op)
      LB:      return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      LHU:     return h;
      default: return w;
    endcase
  endfunction

  function automatic logic model_mis(input logic [5:0] op, input logic [1:0] a);
    if ((op == LH || op == LHU) && (a % 2 == 1)) return 1'b1;
    if (op == LW && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_exc = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return on the falling edge.
  task automatic step(input logic iv, input logic st, input logic fl, input logic [5:0] op,
                      input logic [31:0] md, input logic [31:0] alu, input logic [4:0] rd,
                      input logic rw, input logic m2r);
    logic mis;
    in_valid = iv; stall = st; flush = fl; opcode = op; mem_data = md;
    alu_result = alu; rd_addr = rd; reg_write = rw; mem_to_reg = m2r;
    @(posedge clk);
    if (reset || fl || (!st && !iv)) begin
      model_clear();
    end else if (!st) begin
      mis     = model_mis(op, alu[1:0]);
      m_valid = 1;
      m_rd    = rd;
      m_data  = m2r ? model_ext(op, alu[1:0], md) : alu;
      m_rw    = rw && (rd != 0);
`ifdef LOAD_MISALIGN_TRAP_EN
      m_exc   = mis;
      if (mis) m_rw = 0;
`endif
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    check("valid", 32'(wb_valid), 32'(m_valid));
    check("reg_write", 32'(wb_reg_write), 32'(m_rw));
    check("rd", 32'(wb_rd), 32'(m_rd));
    check("data", wb_data, m_data);
`ifdef LOAD_MISALIGN_TRAP_EN
    check("misalign_exc", 32'(misalign_exc), 32'(m_exc));
`endif
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(wb_valid), 32'h0);
    check("reset_data", wb_data, 32'h0);
    reset = 1'b0;

    step(1, 0, 0, LB, 32'h8012_3456, 32'h0000_1000, 5'd5, 1, 1);
    check("lb_a0_data", wb_data, 32'hFFFF_FF80);
    check("lb_a0_rw", 32'(wb_reg_write), 32'h1);
    step(1, 0, 0, LBU, 32'h1234_F678, 32'h0000_1002, 5'd6, 1, 1);
    check("lbu_a2_data", wb_data, 32'h0000_00F6);
    step(1, 0, 0, LHU, 32'h1234_F678, 32'h0000_1002, 5'd6, 1, 1);
    check("lhu_a2_data", wb_data, 32'h0000_F678);
    step(1, 0, 0, LH, 32'h8001_1234, 32'h0000_2000, 5'd8, 1, 1);
    check("lh_a0_data", wb_data, 32'hFFFF_8001);
    step(1, 0, 0, LB, 32'h0000_00FF, 32'h0000_2003, 5'd8, 1, 1);
    check("lb_a3_data", wb_data, 32'hFFFF_FFFF);
    step(1, 0, 0, LHU, 32'h1234_F678, 32'h0000_2003, 5'd7, 1, 1);
    check("lhu_a3_masked", wb_data, 32'h0000_F678);

    step(1, 0, 0, LW, 32'hDEAD_BEEF, 32'h0000_0100, 5'd9, 1, 1);
    check("lw_data", wb_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, LB, $urandom, $urandom, 5'(i + 1), 1, 1);
      check("stall_hold_data", wb_data, 32'hDEAD_BEEF);
      check("stall_hold_rd", 32'(wb_rd), 32'd9);
    end
    step(1, 1, 1, LW, 32'h1111_2222, 32'h0, 5'd4, 1, 1);
    check("stall_flush_valid", 32'(wb_valid), 32'h0);
    check("stall_flush_data", wb_data, 32'h0);

    step(1, 0, 0, ADD, 32'hAAAA_AAAA, 32'd5, 5'd0, 1, 0);
    check("add_r0_rw", 32'(wb_reg_write), 32'h0);
    check("add_r0_data", wb_data, 32'd5);
    check("add_r0_valid", 32'(wb_valid), 32'h1);
    step(0, 0, 0, LW, 32'h5555_5555, 32'd8, 5'd3, 1, 1);
    check("idle_bubble_valid", 32'(wb_valid), 32'h0);

    step(1, 0, 0, LW, 32'h1122_3344, 32'h0000_0006, 5'd3, 1, 1);
    check("lw_a6_data", wb_data, 32'h1122_3344);
`ifdef LOAD_MISALIGN_TRAP_EN
    check("lw_a6_exc", 32'(misalign_exc), 32'h1);
    check("lw_a6_rw", 32'(wb_reg_write), 32'h0);
`else
    check("lw_a6_rw", 32'(wb_reg_write), 32'h1);
`endif

    // Asynchronous reset in the middle of a stall
    step(1, 0, 0, LW, 32'hCAFE_F00D, 32'h0000_0040, 5'd12, 1, 1);
    step(1, 1, 0, LB, 32'h0, 32'h0, 5'd1, 1, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(wb_valid), 32'h0);
    check("async_rst_rw", 32'(wb_reg_write), 32'h0);
    check("async_rst_rd", 32'(wb_rd), 32'h0);
    check("async_rst_data", wb_data, 32'h0);
    model_clear();
    step(1, 1, 0, LW, 32'hFFFF_FFFF, 32'h0, 5'd2, 1, 1);
    reset = 1'b0;
    step(1, 0, 0, LBU, 32'h1234_F678, 32'h0000_0001, 5'd10, 1, 1);
    check("post_reset_capture", wb_data, 32'h0000_0034);

    for (int i = 0; i < 24; i++) begin
      logic [5:0] op;
      case (i % 6)
        0: op = LB; 1: op = LH; 2: op = LW; 3: op = LBU; 4: op = LHU; default: op = ADD;
      endcase
      step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 6) == 0), op, $urandom, $urandom, 5'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
